serdes_align_ctrl: RTL and testbench
====================================

SERDES_ALIGN_CTRL -- requirements
Module: serdes_align_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: deserialized word width; legal range 3..10.
REQ-002 Parameter PATTERN, default 4'b0011, WIDTH bits: training word.
REQ-003 Parameter MATCH_COUNT, default 8: consecutive matching valid words needed to declare alignment; legal range 1..255.
REQ-004 Parameter SLIP_WAIT, default 4: settle cycles after each bitslip or delay step; legal range 1..255.
REQ-005 Parameter MAX_TAP, default 6'd63: last delay tap tried before failure.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to (re)start alignment.
REQ-009 pll_lock  in  1  PLL locked status.
REQ-010 data_valid  in  1  des_data qualifier from the deserializer.
REQ-011 des_data  in  WIDTH  deserialized word.
REQ-012 dly_tap_value  in  6  current delay tap reported by the deserializer.
REQ-013 bitslip_adj  out  1  one-cycle bitslip pulse.
REQ-014 dly_adj  out  1  one-cycle delay-step pulse.
REQ-015 dly_incdec  out  1  delay direction; 1 = increment.
REQ-016 dly_load  out  1  one-cycle pulse reloading the programmed delay.
REQ-017 fifo_rst  out  1  one-cycle deserializer FIFO reset.
REQ-018 busy  out  1  high in every state except IDLE, LOCKED and FAIL.
REQ-019 aligned  out  1  high only in LOCKED.
REQ-020 align_error  out  1  high only in FAIL.
REQ-021 slip_count  out  4  bitslips issued since the last start or delay step.

Function
REQ-022 States: IDLE, LOAD, CHECK, SLIP, DSTEP, SETTLE, LOCKED, FAIL; all outputs are registered, decoded from the state register.
REQ-023 IDLE/LOCKED/FAIL: start=1 and pll_lock=1 -> LOAD next cycle; start with pll_lock=0 is ignored; start is ignored in all other states.
REQ-024 LOAD: lasts 1 cycle; dly_load=1 and fifo_rst=1; match counter and slip_count cleared; -> SETTLE.
REQ-025 SETTLE: lasts exactly SLIP_WAIT cycles, ignoring data; match counter cleared; -> CHECK.
REQ-026 CHECK, cycles with data_valid=0: no effect.
REQ-027 CHECK, data_valid=1 and des_data==PATTERN: match counter increments; the MATCH_COUNT-th consecutive match -> LOCKED next cycle.
REQ-028 CHECK, data_valid=1 and mismatch with slip_count<WIDTH-1: -> SLIP.
REQ-029 CHECK, data_valid=1 and mismatch with slip_count==WIDTH-1: -> DSTEP if dly_tap_value<MAX_TAP, else -> FAIL.
REQ-030 SLIP: lasts 1 cycle; bitslip_adj=1; slip_count increments; -> SETTLE.
REQ-031 DSTEP: lasts 1 cycle; dly_adj=1 and dly_incdec=1; slip_count cleared to 0; -> SETTLE.
REQ-032 dly_incdec is 1 in DSTEP and 0 otherwise.
REQ-033 At most one of bitslip_adj, dly_adj and dly_load is high in any cycle.
REQ-034 Consecutive bitslip_adj pulses are separated by at least SLIP_WAIT+1 cycles.
REQ-035 LOCKED: des_data is not monitored (payload); the block stays in LOCKED until pll_lock falls or start is accepted.
REQ-036 pll_lock=0 in any state other than IDLE -> IDLE next cycle; all pulse outputs deassert and aligned/align_error clear; this takes priority over every other transition.
REQ-037 FAIL: holds until reset or an accepted start.
REQ-038 A mismatch at any point in CHECK clears the match counter before the slip/step decision.

Reset
REQ-039 reset=1 at a clock edge -> state IDLE, both counters 0 and all outputs 0 from the next cycle, regardless of the current state.
REQ-040 reset has priority over start and pll_lock.

Verification
REQ-041 Assert reset mid-SETTLE -> next cycle all outputs 0 and state IDLE; the later start restarts from LOAD.
REQ-042 WIDTH=4, pll_lock=1, des_data=0011 valid every cycle, start pulse -> dly_load/fifo_rst pulse one cycle later, aligned rises after 4 settle cycles plus 8 matching words, bitslip_adj never pulses.
REQ-043 Model a rotated word (1100) that becomes 0011 after 2 bitslips -> exactly 2 bitslip_adj pulses spaced at least 5 cycles apart, slip_count=2, aligned=1.
REQ-044 Never-matching data with a model tap that increments per dly_adj -> one dly_adj pulse (dly_incdec=1) after every 3 slips; at tap 63 the next phase exhaustion gives align_error=1, busy=0, no further pulses.
REQ-045 Drop pll_lock in LOCKED -> aligned=0 next cycle, state IDLE; start while pll_lock=0 -> no response.
REQ-046 Matching words 1-5 then a mismatch -> one bitslip pulse, and alignment then requires 8 fresh matches.

Source files
------------

// File: rtl/serdes_align_ctrl.sv
// Deserializer word-alignment controller: bitslips through every phase, then steps the input delay, until the training word repeats.
// Outputs are decoded from the registered state; pll_lock loss aborts to IDLE from any state.
module serdes_align_ctrl #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] PATTERN     = 4'b0011,
  parameter int               MATCH_COUNT = 8,
  parameter int               SLIP_WAIT   = 4,
  parameter logic [5:0]       MAX_TAP     = 6'd63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pll_lock,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] des_data,
  input  logic [5:0]       dly_tap_value,
  output logic             bitslip_adj,
  output logic             dly_adj,
  output logic             dly_incdec,
  output logic             dly_load,
  output logic             fifo_rst,
  output logic             busy,
  output logic             aligned,
  output logic             align_error,
  output logic [3:0]       slip_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_SLIP, S_DSTEP, S_SETTLE, S_LOCKED, S_FAIL
  } state_t;

  localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] SLIP_LAST   = 4'(WIDTH - 1);

  state_t     state, state_nxt;
  logic [7:0] match_cnt;
  logic [7:0] settle_cnt;
  logic       word_hit;
  logic       abort;

  assign word_hit = (des_data == PATTERN);
  assign abort    = !pll_lock && (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_LOCKED, S_FAIL: if (start && pll_lock) state_nxt = S_LOAD;
      S_LOAD:                   state_nxt = S_SETTLE;
      S_SETTLE:                 if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
      S_CHECK: begin
        if (data_valid) begin
          if (word_hit) begin
            if (match_cnt == MATCH_LAST) state_nxt = S_LOCKED;
          end else if (slip_count < SLIP_LAST) begin
            state_nxt = S_SLIP;
          end else if (dly_tap_value < MAX_TAP) begin
            state_nxt = S_DSTEP;
          end else begin
            state_nxt = S_FAIL;
          end
        end
      end
      S_SLIP, S_DSTEP:          state_nxt = S_SETTLE;
      default:                  state_nxt = S_IDLE;
    endcase
    // Losing the PLL overrides every other transition.
    if (abort) state_nxt = S_IDLE;

    bitslip_adj = (state == S_SLIP);
    dly_adj     = (state == S_DSTEP);
    dly_incdec  = (state == S_DSTEP);
    dly_load    = (state == S_LOAD);
    fifo_rst    = (state == S_LOAD);
    aligned     = (state == S_LOCKED);
    align_error = (state == S_FAIL);
    busy        = (state != S_IDLE) && (state != S_LOCKED) && (state != S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      match_cnt  <= 8'd0;
      settle_cnt <= 8'd0;
      slip_count <= 4'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      // Counter side effects of a state are dropped when that state is aborted.
      if (!abort) begin
        case (state)
          S_LOAD: begin
            match_cnt  <= 8'd0;
            slip_count <= 4'd0;
          end
          S_SETTLE: match_cnt <= 8'd0;
          S_CHECK:  if (data_valid) match_cnt <= word_hit ? match_cnt + 8'd1 : 8'd0;
          S_SLIP:   slip_count <= slip_count + 4'd1;
          S_DSTEP:  slip_count <= 4'd0;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdes_align_ctrl.sv
// Randomized and directed bench for serdes_align_ctrl against a phase-level reference model and a channel model.
module tb_serdes_align_ctrl;

  localparam int         W    = 4;
  localparam int         MC   = 8;
  localparam int         SW   = 4;
  localparam int         MAXT = 63;
  localparam logic [3:0] PAT  = 4'b0011;

  logic       clk = 1'b0;
  logic       reset, start, pll_lock, data_valid;
  logic [3:0] des_data;
  logic [5:0] dly_tap_value;
  logic       bitslip_adj, dly_adj, dly_incdec, dly_load, fifo_rst;
  logic       busy, aligned, align_error;
  logic [3:0] slip_count;

  serdes_align_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pll_lock(pll_lock),
    .data_valid(data_valid), .des_data(des_data), .dly_tap_value(dly_tap_value),
    .bitslip_adj(bitslip_adj), .dly_adj(dly_adj), .dly_incdec(dly_incdec),
    .dly_load(dly_load), .fifo_rst(fifo_rst), .busy(busy), .aligned(aligned),
    .align_error(align_error), .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // channel model
  int         phase_off, tap_init, valid_pct, corrupt_pct, inject_at, chk_words;
  bit         fixed_mode;
  logic [3:0] fixed_word;
  int         n_slip, n_dadj, n_load, n_bad_dir, last_slip_cyc;

  // reference model
  typedef enum int {M_IDLE, M_LOAD, M_SETTLE, M_CHECK, M_SLIP, M_STEP, M_LOCKED, M_FAIL} mphase_t;
  mphase_t mph;
  int      m_slips, m_run, m_settle;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r;
    r = w;
    for (int k = 0; k < n % W; k++) r = {r[2:0], r[3]};
    return r;
  endfunction

  function automatic int dut_outs();
    return 32'({bitslip_adj, dly_adj, dly_incdec, dly_load, fifo_rst,
                busy, aligned, align_error, slip_count});
  endfunction

  function automatic int model_outs();
    logic mbusy;
    mbusy = !(mph == M_IDLE || mph == M_LOCKED || mph == M_FAIL);
    return 32'({mph == M_SLIP, mph == M_STEP, mph == M_STEP, mph == M_LOAD, mph == M_LOAD,
                mbusy, mph == M_LOCKED, mph == M_FAIL, 4'(m_slips)});
  endfunction

  task automatic enter_settle();
    mph      = M_SETTLE;
    m_settle = SW;
  endtask

  task automatic model_step();
    if (reset) begin
      mph = M_IDLE; m_slips = 0; m_run = 0;
    end else if (!pll_lock && mph != M_IDLE) begin
      mph = M_IDLE;
    end else begin
      case (mph)
        M_IDLE, M_LOCKED, M_FAIL: if (start && pll_lock) mph = M_LOAD;
        M_LOAD: begin m_slips = 0; m_run = 0; enter_settle(); end
        M_SETTLE: begin
          m_run = 0;
          m_settle--;
          if (m_settle == 0) mph = M_CHECK;
        end
        M_CHECK: begin
          if (data_valid) begin
            if (des_data == PAT) begin
              m_run++;
              if (m_run == MC) mph = M_LOCKED;
            end else begin
              m_run = 0;
              if (m_slips < W - 1) mph = M_SLIP;
              else if (int'(dly_tap_value) < MAXT) mph = M_STEP;
              else mph = M_FAIL;
            end
          end
        end
        M_SLIP: begin m_slips++; enter_settle(); end
        M_STEP: begin m_slips = 0; enter_settle(); end
        default: mph = M_IDLE;
      endcase
    end
  endtask

  task automatic drive_data();
    logic [3:0] w;
    data_valid = ($urandom_range(99) < valid_pct);
    w = fixed_mode ? fixed_word : rotl(PAT, phase_off);
    if ($urandom_range(99) < corrupt_pct) w = w ^ 4'($urandom_range(15, 1));
    if (mph == M_CHECK && data_valid) begin
      chk_words++;
      if (chk_words == inject_at) w = ~PAT;
    end
    des_data = w;
  endtask

  task automatic observe();
    if (bitslip_adj) begin
      n_slip++;
      check_eq("slip_gap_ok", int'((cyc - last_slip_cyc) >= SW + 1), 1);
      last_slip_cyc = cyc;
      phase_off = (phase_off + 1) % W;
    end
    if (dly_adj) begin
      n_dadj++;
      if (!dly_incdec) n_bad_dir++;
      if (dly_tap_value < 6'd63) dly_tap_value = dly_tap_value + 6'd1;
    end
    if (dly_load) begin
      n_load++;
      dly_tap_value = 6'(tap_init);
    end
  endtask

  task automatic tick();
    drive_data();
    model_step();
    cyc++;
    @(negedge clk);
    check_eq("outs", dut_outs(), model_outs());
    observe();
  endtask

  task automatic clr_counts();
    n_slip = 0; n_dadj = 0; n_load = 0; n_bad_dir = 0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; pll_lock = 1'b1; data_valid = 1'b0;
    des_data = 4'd0; dly_tap_value = 6'd0;
    fixed_mode = 1'b0; fixed_word = PAT; phase_off = 0; tap_init = 0;
    valid_pct = 100; corrupt_pct = 0; inject_at = 0; chk_words = 0;
    last_slip_cyc = -100;
    mph = M_IDLE; m_slips = 0; m_run = 0; m_settle = 0;
    clr_counts();

    repeat (3) tick();
    check_eq("reset_outs", dut_outs(), 0);
    reset = 1'b0;
    tick();

    // Already-aligned channel.
    clr_counts();
    start_pulse();
    s = cyc;
    check_eq("load_fifo_pulse", 32'({dly_load, fifo_rst}), 3);
    for (int i = 0; i < 100 && !aligned; i++) tick();
    check_eq("lock_direct", 32'(aligned), 1);
    check_eq("lat_direct", cyc - s, 1 + SW + MC);
    check_eq("slips_direct", n_slip, 0);

    // Word rotated by two bits.
    phase_off = 2;
    clr_counts();
    start_pulse();
    for (int i = 0; i < 200 && !aligned; i++) tick();
    check_eq("lock_rot", 32'(aligned), 1);
    check_eq("slips_rot", n_slip, 2);
    check_eq("slip_count_rot", 32'(slip_count), 2);

    // PLL loss while locked, then start without lock.
    pll_lock = 1'b0;
    tick();
    check_eq("unlock_aligned", 32'(aligned), 0);
    check_eq("unlock_busy", 32'(busy), 0);
    clr_counts();
    start_pulse();
    repeat (4) tick();
    check_eq("nolock_start", n_load, 0);
    pll_lock = 1'b1;
    tick();

    // Five matches, one bad word, then a full fresh run.
    fixed_mode = 1'b1; fixed_word = PAT; chk_words = 0; inject_at = 6;
    clr_counts();
    start_pulse();
    s = cyc;
    for (int i = 0; i < 200 && !aligned; i++) tick();
    check_eq("lock_inject", 32'(aligned), 1);
    check_eq("slips_inject", n_slip, 1);
    check_eq("lat_inject", cyc - s, 1 + SW + 6 + 1 + SW + MC);
    inject_at = 0;

    // Reset in the middle of settling.
    start_pulse();
    tick();
    tick();
    check_eq("mid_settle_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    check_eq("rst_mid", dut_outs(), 0);
    reset = 1'b0;
    tick();
    start_pulse();
    check_eq("restart_load", 32'(dly_load), 1);
    for (int i = 0; i < 100 && !aligned; i++) tick();
    check_eq("lock_after_rst", 32'(aligned), 1);

    // Never-matching data sweeps every tap then fails.
    fixed_word = 4'b1111; tap_init = 0;
    clr_counts();
    start_pulse();
    for (int i = 0; i < 5000 && !align_error; i++) tick();
    check_eq("fail_flag", 32'(align_error), 1);
    check_eq("fail_busy", 32'(busy), 0);
    check_eq("fail_dsteps", n_dadj, MAXT);
    check_eq("fail_dir", n_bad_dir, 0);
    check_eq("fail_slips", n_slip, (MAXT + 1) * (W - 1));
    check_eq("fail_tap", 32'(dly_tap_value), MAXT);
    clr_counts();
    repeat (20) tick();
    check_eq("fail_quiet", n_slip + n_dadj + n_load, 0);
    check_eq("fail_hold", 32'(align_error), 1);

    // Random traffic on a rotating, noisy channel.
    fixed_mode = 1'b0; valid_pct = 75; corrupt_pct = 3;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(99) < 3);
      if (start) tap_init = $urandom_range(63, 56);
      if (pll_lock && $urandom_range(99) < 1) pll_lock = 1'b0;
      else if (!pll_lock && $urandom_range(99) < 20) pll_lock = 1'b1;
      reset = ($urandom_range(999) < 3);
      tick();
    end
    reset = 1'b0; start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
